// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with frame-level debounce and a
// one-deep event register (key_code/key_valid) with ack handshake and a
// sticky overflow flag.
// Optional feature: define KEYPAD_SCANNER_REPEAT_EN to enable auto-repeat of
// a held key every REPEAT_FRAMES frames.
module keypad_scanner #(
  parameter int SCAN_DIV      = 4,
  parameter int DEBOUNCE      = 3,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  if (SCAN_DIV < 2 || SCAN_DIV > 255 || DEBOUNCE < 1 || DEBOUNCE > 15 ||
      REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_bad_param
    $error("keypad_scanner: parameter out of legal range");
  end

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  logic [7:0] div_cnt;
  logic [1:0] col_idx;
  logic       sample, frame_end;

  logic [1:0] acc_cnt;   // lows seen so far this frame, saturating at 2
  logic [3:0] acc_code;  // code of the first single low seen this frame
  logic [3:0] lows;
  logic [2:0] pc, tot_sum;
  logic [1:0] row_idx, tot;
  logic [3:0] frm_code;
  logic       is_single;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx, cand, cand_nx;
  logic       emit;
`ifdef KEYPAD_SCANNER_REPEAT_EN
  logic [7:0] rpt, rpt_nx;
`endif

  assign sample    = (div_cnt == 8'(SCAN_DIV - 1));
  assign frame_end = sample && (col_idx == 2'd3);
  assign col_n     = ~(4'b0001 << col_idx);

  // column strobe timing: dwell SCAN_DIV cycles per column, wrap after col 3
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      col_idx <= '0;
    end else if (sample) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  // classify the current column sample merged with the frame so far
  always_comb begin
    lows    = ~row_n;
    pc      = 3'(lows[0]) + 3'(lows[1]) + 3'(lows[2]) + 3'(lows[3]);
    row_idx = '0;
    for (int r = 0; r < 4; r++)
      if (lows[r]) row_idx = 2'(r);
    tot_sum   = {1'b0, acc_cnt} + pc;
    tot       = (tot_sum >= 3'd2) ? 2'd2 : tot_sum[1:0];
    frm_code  = (acc_cnt == 2'd0 && pc == 3'd1) ? {col_idx, row_idx} : acc_code;
    is_single = (tot == 2'd1);
  end

  // per-frame accumulator, cleared at the column-3 sample
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt  <= '0;
      acc_code <= '0;
    end else if (sample) begin
      if (col_idx == 2'd3) begin
        acc_cnt  <= '0;
        acc_code <= '0;
      end else begin
        acc_cnt  <= tot;
        acc_code <= frm_code;
      end
    end
  end

  // debounce FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rpt   <= '0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rpt   <= rpt_nx;
`endif
    end
  end

  // debounce FSM next state; advances only once per frame
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    emit     = 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
    rpt_nx   = rpt;
`endif
    if (frame_end) begin
      case (state)
        IDLE: if (is_single) begin
          cand_nx = frm_code;
          cnt_nx  = 4'd1;
          if (DEB == 4'd1) begin
            state_nx = HELD;
            emit     = 1'b1;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rpt_nx   = '0;
`endif
          end else begin
            state_nx = PRESS_DB;
          end
        end
        PRESS_DB: if (is_single && frm_code == cand) begin
          cnt_nx = cnt + 4'd1;
          if (cnt + 4'd1 == DEB) begin
            state_nx = HELD;
            emit     = 1'b1;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rpt_nx   = '0;
`endif
          end
        end else begin
          // a different key, a multi-key frame or no key all restart
          state_nx = IDLE;
          cnt_nx   = '0;
        end
        HELD: if (is_single && frm_code == cand) begin
`ifdef KEYPAD_SCANNER_REPEAT_EN
          rpt_nx = rpt + 8'd1;
          if (rpt + 8'd1 == 8'(REPEAT_FRAMES)) begin
            emit   = 1'b1;
            rpt_nx = '0;
          end
`endif
        end else begin
          cnt_nx   = 4'd1;
          state_nx = (DEB == 4'd1) ? IDLE : RELEASE_DB;
        end
        RELEASE_DB: if (is_single && frm_code == cand) begin
          state_nx = HELD;
        end else begin
          cnt_nx = cnt + 4'd1;
          if (cnt + 4'd1 == DEB) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // event register: accept when empty or being acked, else drop and flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (emit) begin
      if (!key_valid || key_ack) begin
        key_code  <= frm_code;
        key_valid <= 1'b1;
      end else begin
        overflow  <= 1'b1;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=3, 16-cycle frame).
// A behavioural keypad drives row_n from col_n and a 16-bit pressed-key mask.
// Expected key codes are queued when a press is applied and popped when the
// DUT presents an event.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col_n, row_n, key_code;
  logic       key_valid, key_ack, overflow;
  logic [15:0] keys;

  int n_cmp = 0;
  int n_fail = 0;
  int cy = 0;
  logic [3:0] sb[$];
  logic seen;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_FRAMES(8)) dut (
    .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // keypad matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_n[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row_n[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic chk_event(input string tag);
    logic [3:0] e;
    chk({tag, "_valid"}, 8'(key_valid), 8'd1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_sb: observed event %0h expected none queued", tag, key_code);
    end else begin
      e = sb.pop_front();
      chk({tag, "_code"}, 8'(key_code), 8'(e));
    end
  endtask

  task automatic wait_to(input int target);
    while (cy < target) begin
      @(negedge clk);
      cy++;
    end
  endtask

  // hold reset, check reset outputs, release at a negedge: cycle 0 begins
  task automatic start(input logic [15:0] k);
    reset   = 1'b0;
    key_ack = 1'b0;
    keys    = k;
    @(negedge clk);
    @(negedge clk);
    chk("rst_col", 8'(col_n), 8'h0E);
    chk("rst_valid", 8'(key_valid), 8'd0);
    chk("rst_code", 8'(key_code), 8'd0);
    chk("rst_ovf", 8'(overflow), 8'd0);
    reset = 1'b1;
    cy = 0;
  endtask

  initial begin
    int rpt_t[3];
    rpt_t = '{48, 176, 304};
    reset = 1'b0; key_ack = 1'b0; keys = '0;

    // column stepping with no keys
    start(16'h0000);
    chk("scan_c0", 8'(col_n), 8'h0E);
    wait_to(3);  chk("scan_c3", 8'(col_n), 8'h0E);
    wait_to(4);  chk("scan_c4", 8'(col_n), 8'h0D);
    wait_to(8);  chk("scan_c8", 8'(col_n), 8'h0B);
    wait_to(12); chk("scan_c12", 8'(col_n), 8'h07);
    wait_to(16); chk("scan_c16", 8'(col_n), 8'h0E);
    chk("scan_valid", 8'(key_valid), 8'd0);
    chk("scan_ovf", 8'(overflow), 8'd0);

    // key col2/row1 held from cycle 0: event exactly at cycle 48
    start(16'h0200);
    sb.push_back(4'd9);
    wait_to(47); chk("k9_early", 8'(key_valid), 8'd0);
    wait_to(48); chk_event("k9");
    wait_to(100);
    chk("k9_hold_valid", 8'(key_valid), 8'd1);
    chk("k9_hold_code", 8'(key_code), 8'd9);
    key_ack = 1'b1;
    wait_to(101); key_ack = 1'b0;
    chk("k9_ack", 8'(key_valid), 8'd0);
    keys = '0;

    // bounce: present 2 frames, absent 1, present 3 -> one event at cycle 96
    start(16'h0001);
    wait_to(32); keys = 16'h0000;
    wait_to(48); keys = 16'h0001;
    sb.push_back(4'd0);
    wait_to(95); chk("bounce_early", 8'(key_valid), 8'd0);
    wait_to(96); chk_event("bounce");
    key_ack = 1'b1;
    wait_to(97); key_ack = 1'b0;
    chk("bounce_ack", 8'(key_valid), 8'd0);
    seen = 1'b0;
    while (cy < 160) begin wait_to(cy + 1); seen |= key_valid; end
    chk("bounce_single", 8'(seen), 8'd0);
    keys = '0;

    // two keys in different columns for 10 frames -> never an event
    start(16'h4010);
    seen = 1'b0;
    while (cy < 160) begin wait_to(cy + 1); seen |= key_valid; end
    chk("multi_none", 8'(seen), 8'd0);
    chk("multi_ovf", 8'(overflow), 8'd0);
    keys = '0;

    // overflow on unacked second event, then event coinciding with ack
    start(16'h0020);
    sb.push_back(4'd5);
    wait_to(48); chk_event("ov5");
    keys = 16'h0000;
    wait_to(96); keys = 16'h0400;
    wait_to(143); chk("ov_pre", 8'(overflow), 8'd0);
    wait_to(144);
    chk("ov_set", 8'(overflow), 8'd1);
    chk("ov_keep_valid", 8'(key_valid), 8'd1);
    chk("ov_keep_code", 8'(key_code), 8'd5);
    keys = 16'h0000;
    wait_to(192); keys = 16'h0080;
    sb.push_back(4'd7);
    wait_to(239); key_ack = 1'b1;
    wait_to(240); key_ack = 1'b0;
    chk_event("coinc7");
    chk("coinc_ovf", 8'(overflow), 8'd1);
    wait_to(244); key_ack = 1'b1;
    wait_to(245); key_ack = 1'b0;
    chk("ack_valid", 8'(key_valid), 8'd0);
    chk("ack_ovf", 8'(overflow), 8'd0);
    wait_to(250); key_ack = 1'b1;
    wait_to(251); key_ack = 1'b0;
    chk("idle_ack_valid", 8'(key_valid), 8'd0);
    chk("idle_ack_code", 8'(key_code), 8'd7);
    keys = '0;

    // reset mid-press discards progress and asserts immediately
    start(16'h0200);
    wait_to(40);
    reset = 1'b0;
    #1;
    chk("mid_rst_col", 8'(col_n), 8'h0E);
    chk("mid_rst_valid", 8'(key_valid), 8'd0);
    @(negedge clk);
    reset = 1'b1;
    cy = 0;
    sb.push_back(4'd9);
    wait_to(47); chk("mid_rst_early", 8'(key_valid), 8'd0);
    wait_to(48); chk_event("mid_rst");
    keys = '0;

    // code 3 held 20 frames, ack after each event
    start(16'h0008);
`ifdef KEYPAD_SCANNER_REPEAT_EN
    for (int i = 0; i < 3; i++) begin
      sb.push_back(4'd3);
      wait_to(rpt_t[i] - 1); chk("rpt_early", 8'(key_valid), 8'd0);
      wait_to(rpt_t[i]);     chk_event("rpt");
      key_ack = 1'b1;
      wait_to(rpt_t[i] + 1); key_ack = 1'b0;
      chk("rpt_ack", 8'(key_valid), 8'd0);
    end
`else
    sb.push_back(4'd3);
    wait_to(rpt_t[0] - 1); chk("once_early", 8'(key_valid), 8'd0);
    wait_to(rpt_t[0]);     chk_event("once");
    key_ack = 1'b1;
    wait_to(rpt_t[0] + 1); key_ack = 1'b0;
    seen = 1'b0;
    while (cy < 320) begin wait_to(cy + 1); seen |= key_valid; end
    chk("once_norepeat", 8'(seen), 8'd0);
`endif
    keys = '0;

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 4, giving the clock cycles each column strobe is held (legal 2..255).
REQ-002 The module SHALL have parameter DEBOUNCE, default 3, giving the consecutive identical frames needed to accept a press or a release (legal 1..15).
REQ-003 The module SHALL have parameter REPEAT_FRAMES, default 8, giving the auto-repeat period in frames; it is used only with KEYPAD_SCANNER_REPEAT_EN.
REQ-004 Port clk  input  1  sole clock; all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port col_n  output  4  active-low one-hot column strobe to keypad.
REQ-007 Port row_n  input  4  active-low row returns from keypad, pre-synchronised externally.
REQ-008 Port key_code  output  4  accepted key, encoded col_idx*4+row_idx.
REQ-009 Port key_valid  output  1  key_code holds an unconsumed event.
REQ-010 Port key_ack  input  1  consumer accepts the pending event.
REQ-011 Port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-012 col_n SHALL step 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing after SCAN_DIV cycles per column; one frame = 4*SCAN_DIV cycles.
REQ-013 row_n SHALL be sampled once per column, in the last dwell cycle of that column.
REQ-014 Frame result, evaluated at the column-3 sample: NONE = no row low in any column; SINGLE(code) = exactly one low row across the whole frame; MULTI = otherwise, and MULTI SHALL be treated as NONE that also resets the debounce count.
REQ-015 The FSM SHALL have the states IDLE, PRESS_DB, HELD and RELEASE_DB.
REQ-016 IDLE: on SINGLE(c), latch the candidate c, set cnt=1 and go to PRESS_DB (go straight to HELD and emit if DEBOUNCE=1).
REQ-017 PRESS_DB: on SINGLE of the same c, increment cnt; when cnt reaches DEBOUNCE, emit the event and go to HELD; on any other result, go to IDLE.
REQ-018 HELD: on SINGLE(c), stay; on any other result, set cnt=1 and go to RELEASE_DB.
REQ-019 RELEASE_DB: on NONE or MULTI, increment cnt and go to IDLE when cnt reaches DEBOUNCE; on SINGLE(c), return to HELD with no new event.
REQ-020 An emitted event SHALL drive key_valid high and key_code=c on the cycle after the deciding sample edge; latency from the first frame of a stable press is exactly DEBOUNCE frames + 1 cycle.
REQ-021 key_code SHALL be stable while key_valid=1; key_valid SHALL clear on the cycle after key_ack=1 and key_valid=1 are sampled together.
REQ-022 key_ack while key_valid=0 SHALL be ignored.
REQ-023 An event that coincides with an ack SHALL be accepted: key_valid stays 1, key_code updates, overflow is unchanged.
REQ-024 An event while key_valid=1 and key_ack=0 SHALL be dropped: key_code is kept and overflow is set to 1.
REQ-025 overflow SHALL clear only on reset or on an accepted key_ack.

Reset
REQ-026 Asserting reset (low) SHALL immediately set col_n=1110, key_code=0, key_valid=0, overflow=0, FSM=IDLE, and all counters and the candidate to 0.
REQ-027 Reset mid-press SHALL discard all progress; after release of reset, scanning restarts at column 0 and a still-held key needs a full DEBOUNCE frames again.

Configuration
REQ-028 With KEYPAD_SCANNER_REPEAT_EN defined, the HELD state SHALL emit the same code again every REPEAT_FRAMES frames held, counted from the initial event, under REQ-021..REQ-025.
REQ-029 Without KEYPAD_SCANNER_REPEAT_EN, exactly one event SHALL be emitted per accepted press, and no repeat counter logic SHALL be present.

Verification (SCAN_DIV=4, DEBOUNCE=3, frame=16 cycles)
REQ-030 Reset, no keys -> col_n=1110 for cycles 0-3, 1101 at cycle 4, 1110 again at cycle 16; key_valid and overflow stay 0.
REQ-031 Key col2/row1 held from cycle 0 (row_n=1101 only while col_n=1011), no ack -> key_valid=1 and key_code=9 at cycle 48; key_valid stays 1 while held.
REQ-032 Bounce on col0/row0: present 2 frames, absent 1, present 3 -> exactly one event, key_code=0, at the end of frame 6 + 1 cycle.
REQ-033 col1/row0 and col3/row2 pressed together for 10 frames -> no event; FSM stays IDLE.
REQ-034 Press/release code 5, then press code 10 with no ack -> key_code stays 5, overflow=1; key_ack pulse -> key_valid=0 and overflow=0 one cycle later.
REQ-035 With KEYPAD_SCANNER_REPEAT_EN, code 3 held for 20 frames with an ack after each event -> events at frames 3, 11 and 19.
